// File: rtl/ram_burst_pkg.sv
// Shared definitions for the RAM burst sequencer.
//   burstState_t : sequencer FSM states (Idle, Rd, Drain, Wr)
//   CDefLenLen   : default width of the burst length field
//   CBufDepth    : depth of the read-data output buffer
package ram_burst_pkg;

  typedef enum logic [1:0] {
    SIdle  = 2'd0,
    SRd    = 2'd1,
    SDrain = 2'd2,
    SWr    = 2'd3
  } burstState_t;

  localparam int CDefLenLen = 8;
  localparam int CBufDepth  = 2;

endpackage

// File: rtl/ram_burst_fifo2.sv
// Two-entry FIFO holding read data captured from the RAM until the consumer
// takes it.
//   clkH, resetH  : clock, asynchronous active-high reset (flushes the FIFO)
//   clkEn         : clock enable; nothing moves while it is 0
//   push/pushData : write side
//   pop/popData   : read side; popData is the head entry
//   occupancy     : number of stored entries (0..2)
//   empty         : occupancy == 0
module ram_burst_fifo2
  import ram_burst_pkg::*;
#(
  parameter int CDataLen = 128
) (
  input  logic                clkH,
  input  logic                resetH,
  input  logic                clkEn,
  input  logic                push,
  input  logic [CDataLen-1:0] pushData,
  input  logic                pop,
  output logic [CDataLen-1:0] popData,
  output logic [1:0]          occupancy,
  output logic                empty
);

  logic [CDataLen-1:0] mem [CBufDepth];
  logic                wrPtr;
  logic                rdPtr;
  logic [1:0]          count;
  logic                doPush;
  logic                doPop;

  // A push into a full FIFO is only accepted when a pop frees a slot in the
  // same cycle.
  assign doPop  = clkEn & pop & (count != 2'd0);
  assign doPush = clkEn & push & ((count != 2'd2) | doPop);

  always_ff @(posedge clkH or posedge resetH) begin
    if (resetH) begin
      wrPtr <= 1'b0;
      rdPtr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (doPush) wrPtr <= ~wrPtr;
      if (doPop)  rdPtr <= ~rdPtr;
      case ({doPush, doPop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; the flushed pointers make stale contents invisible.
  always_ff @(posedge clkH) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  assign popData   = mem[rdPtr];
  assign occupancy = count;
  assign empty     = (count == 2'd0);

endmodule

// File: rtl/ram_burst_seq.sv
// Burst sequencer in front of a single-port synchronous RAM (one-cycle read
// latency, gated read data). Takes one read or write burst at a time and
// walks the RAM address word by word.
//   AClkH, AResetH, AClkHEn       : clock, async active-high reset, clock enable
//   AReqAddr/Len/Wr/Valid/Ready  : burst request (Len = words - 1)
//   AWrData/AWrValid/AWrReady    : write-burst data stream
//   ARdData/ARdValid/ARdReady    : read-burst data stream from a 2-entry buffer
//   ARamAddr/Mosi/Miso/WrEn/RdEn : RAM port
//   ABusy                        : burst active or read buffer not yet drained
module ram_burst_seq
  import ram_burst_pkg::*;
#(
  parameter int CAddrLen = 13,
  parameter int CDataLen = 128,
  parameter int CLenLen  = CDefLenLen
) (
  input  logic                AClkH,
  input  logic                AResetH,
  input  logic                AClkHEn,
  input  logic [CAddrLen-1:0] AReqAddr,
  input  logic [CLenLen-1:0]  AReqLen,
  input  logic                AReqWr,
  input  logic                AReqValid,
  output logic                AReqReady,
  input  logic [CDataLen-1:0] AWrData,
  input  logic                AWrValid,
  output logic                AWrReady,
  output logic [CDataLen-1:0] ARdData,
  output logic                ARdValid,
  input  logic                ARdReady,
  output logic [CAddrLen-1:0] ARamAddr,
  output logic [CDataLen-1:0] ARamMosi,
  input  logic [CDataLen-1:0] ARamMiso,
  output logic                ARamWrEn,
  output logic                ARamRdEn,
  output logic                ABusy
);

  burstState_t         state;
  burstState_t         nextState;
  logic [CAddrLen-1:0] fAddr;
  logic [CLenLen-1:0]  remCnt;
  logic                inFlight;
  logic                issue;
  logic                wrBeat;
  logic                push;
  logic                popNow;
  logic [1:0]          occ;
  logic [1:0]          credit;
  logic                bufEmpty;

  // Read data sits on ARamMiso for exactly the cycle after issue; it is
  // captured on the next enabled cycle (the RAM shares the clock enable).
  assign push   = inFlight & AClkHEn;
  assign popNow = ARdValid & ARdReady & AClkHEn;

  // Counting this cycle's pop as freed space is what sustains one word per
  // cycle; the sum can never exceed the buffer depth.
  assign credit = occ + {1'b0, inFlight} - {1'b0, popNow};

  ram_burst_fifo2 #(
    .CDataLen (CDataLen)
  ) uRdBuf (
    .clkH      (AClkH),
    .resetH    (AResetH),
    .clkEn     (AClkHEn),
    .push      (push),
    .pushData  (ARamMiso),
    .pop       (ARdReady),
    .popData   (ARdData),
    .occupancy (occ),
    .empty     (bufEmpty)
  );

  assign ARdValid = ~bufEmpty;
  assign ARamAddr = fAddr;
  assign ARamMosi = AWrData;
  assign ABusy    = (state != SIdle) | ~bufEmpty;

  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      state <= SIdle;
    end else if (AClkHEn) begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      SIdle:  if (AReqValid && AClkHEn) nextState = AReqWr ? SWr : SRd;
      SRd:    if (issue && (remCnt == '0)) nextState = SDrain;
      SDrain: if (!inFlight || push) nextState = SIdle;
      SWr:    if (wrBeat && (remCnt == '0)) nextState = SIdle;
      default: nextState = SIdle;
    endcase
  end

  always_comb begin
    AReqReady = 1'b0;
    AWrReady  = 1'b0;
    ARamWrEn  = 1'b0;
    ARamRdEn  = 1'b0;
    issue     = 1'b0;
    wrBeat    = 1'b0;
    case (state)
      SIdle: AReqReady = AClkHEn;
      SWr: begin
        AWrReady = AClkHEn;
        wrBeat   = AWrValid & AClkHEn;
        ARamWrEn = AWrValid & AClkHEn;
      end
      SRd: begin
        issue    = AClkHEn & (credit < 2'd2);
        ARamRdEn = AClkHEn & (credit < 2'd2);
      end
      default: ;
    endcase
  end

  // Address / count / in-flight registers
  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      fAddr    <= '0;
      remCnt   <= '0;
      inFlight <= 1'b0;
    end else if (AClkHEn) begin
      if ((state == SIdle) && AReqValid) begin
        fAddr  <= AReqAddr;
        remCnt <= AReqLen;
      end else if (issue || wrBeat) begin
        // Address wraps naturally at 2^CAddrLen.
        fAddr  <= fAddr + CAddrLen'(1);
        remCnt <= remCnt - CLenLen'(1);
      end
      if (issue) begin
        inFlight <= 1'b1;
      end else if (push) begin
        inFlight <= 1'b0;
      end
    end
  end

endmodule
